regfile_wb: RTL and testbench

//  Register file that consumes the destination index chosen by the write-address select (rd/rt/$31).

---
 rtl/cpu_pkg.sv | 7 +
 rtl/regfile_scoreboard.sv | 40 ++++
 rtl/regfile_wb.sv | 89 ++++++++
 tb/tb_regfile_wb.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths and the architecturally special register indexes.
package cpu_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for loads in flight, with two combinational lookup ports.
module regfile_scoreboard #(
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic              hit1,
    output logic              hit2
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;

    // Set is applied after clear so a newer load to the same index stays outstanding.
    always_comb begin
        pending_nxt = pending;
        if (clr)
            pending_nxt[clr_addr] = 1'b0;
        if (set)
            pending_nxt[set_addr] = 1'b1;
        pending_nxt[cpu_pkg::REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    assign hit1 = pending[addr1];
    assign hit2 = pending[addr2];
endmodule

// File: rtl/regfile_wb.sv
// Register file with a one-entry write-back latch, read bypass and load scoreboard.
module regfile_wb #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic              hazard1,
    output logic              hazard2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic [1:0][ADDR_W-1:0] raddr;
    logic [1:0][DATA_W-1:0] rdata;
    logic                   hit1;
    logic                   hit2;

    // Writes to index 0 never enter the latch, so the array entry 0 stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            wb_valid <= we && (waddr != '0);
            wb_addr  <= waddr;
            wb_data  <= wdata;
            if (wb_valid)
                mem[wb_addr] <= wb_data;
        end
    end

    assign raddr = {raddr2, raddr1};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [DATA_W-1:0] val;
        always_comb begin
            val = '0;
            if (!rst && raddr[p] != '0) begin
                if (BYPASS && we && waddr == raddr[p])
                    val = wdata;
                else if (BYPASS && wb_valid && wb_addr == raddr[p])
                    val = wb_data;
                else
                    val = mem[raddr[p]];
            end
        end
        assign rdata[p] = val;
    end

    assign rdata1   = rdata[0];
    assign rdata2   = rdata[1];
    assign dbg_data = rst ? '0 : mem[dbg_addr];

    regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set      (pend_set),
        .set_addr (pend_addr),
        .clr      (we),
        .clr_addr (waddr),
        .addr1    (raddr1),
        .addr2    (raddr2),
        .hit1     (hit1),
        .hit2     (hit2)
    );

    assign hazard1 = hit1 && !rst;
    assign hazard2 = hit2 && !rst;
endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: latch bypass, index 0, scoreboard priority, mid-run reset.
module tb_regfile_wb;
    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic        hazard1;
    logic        hazard2;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;

    regfile_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change 1ns after it, checks follow 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; pend_set = 1'b0; pend_addr = '0; dbg_addr = '0;

        // Outputs forced to zero while reset is held, even with a same-cycle write.
        we = 1'b1; waddr = 5'd5; wdata = 32'h1111_2222; raddr1 = 5'd5;
        #1;
        chk("rst_rdata1", rdata1, 32'h0);
        tick();
        we = 1'b0;
        tick();
        rst = 1'b0;
        #1;

        // 1: clean array after reset
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk($sformatf("reset_dbg%0d", i), dbg_data, 32'h0);
        end
        chk("reset_hz1", {31'b0, hazard1}, 32'h0);
        chk("reset_hz2", {31'b0, hazard2}, 32'h0);

        // 2: same-cycle bypass, then latch bypass, then array
        tick();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr1 = 5'd5; raddr2 = 5'd6; dbg_addr = 5'd5;
        #1;
        chk("t2_same", rdata1, 32'hDEAD_BEEF);
        chk("t2_other", rdata2, 32'h0);
        tick();
        we = 1'b0; wdata = 32'h0;
        #1;
        chk("t2_latch", rdata1, 32'hDEAD_BEEF);
        chk("t2_dbg_early", dbg_data, 32'h0);
        tick();
        chk("t2_dbg", dbg_data, 32'hDEAD_BEEF);
        raddr2 = 5'd5;
        #1;
        chk("t2_rd2_array", rdata2, 32'hDEAD_BEEF);

        // 3: index 0 writes dropped
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678; raddr1 = 5'd0; dbg_addr = 5'd0;
        #1;
        chk("t3_same", rdata1, 32'h0);
        tick();
        we = 1'b0;
        #1;
        chk("t3_latch", rdata1, 32'h0);
        tick();
        chk("t3_dbg", dbg_data, 32'h0);

        // 4: back-to-back writes to 31
        we = 1'b1; waddr = 5'd31; wdata = 32'd1; raddr1 = 5'd31; dbg_addr = 5'd31;
        #1;
        chk("t4_first", rdata1, 32'd1);
        tick();
        wdata = 32'd2;
        #1;
        chk("t4_second", rdata1, 32'd2);
        tick();
        we = 1'b0; wdata = 32'h0;
        #1;
        chk("t4_latch", rdata1, 32'd2);
        chk("t4_dbg_mid", dbg_data, 32'd1);
        tick();
        chk("t4_array", rdata1, 32'd2);
        chk("t4_dbg", dbg_data, 32'd2);

        // 5: scoreboard set/clear priority
        pend_set = 1'b1; pend_addr = 5'd8; raddr1 = 5'd8;
        #1;
        chk("t5_before", {31'b0, hazard1}, 32'h0);
        tick();
        pend_set = 1'b0;
        #1;
        chk("t5_set", {31'b0, hazard1}, 32'h1);
        we = 1'b1; waddr = 5'd8; wdata = 32'h77; pend_set = 1'b1;
        tick();
        we = 1'b0; pend_set = 1'b0;
        #1;
        chk("t5_set_wins", {31'b0, hazard1}, 32'h1);
        chk("t5_rd_latch", rdata1, 32'h77);
        we = 1'b1; waddr = 5'd8; wdata = 32'h88;
        #1;
        chk("t5_clr_cycle", {31'b0, hazard1}, 32'h1);
        tick();
        we = 1'b0;
        #1;
        chk("t5_cleared", {31'b0, hazard1}, 32'h0);
        pend_set = 1'b1; pend_addr = 5'd0; raddr2 = 5'd0;
        tick();
        pend_set = 1'b0;
        #1;
        chk("t5_zero_hz", {31'b0, hazard2}, 32'h0);

        // 6: reset discards in-flight latch and pending bits
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5; pend_set = 1'b1; pend_addr = 5'd9;
        tick();
        we = 1'b0; pend_set = 1'b0; raddr1 = 5'd3; raddr2 = 5'd9; dbg_addr = 5'd3;
        #1;
        chk("t6_latch", rdata1, 32'hA5);
        chk("t6_hz_pre", {31'b0, hazard2}, 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_rd_rst", rdata1, 32'h0);
        chk("t6_hz_rst", {31'b0, hazard2}, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_dbg3", dbg_data, 32'h0);
        chk("t6_rd3", rdata1, 32'h0);
        chk("t6_hz9", {31'b0, hazard2}, 32'h0);
        tick();
        chk("t6_dbg3_late", dbg_data, 32'h0);
        dbg_addr = 5'd5;
        #1;
        chk("t6_dbg5", dbg_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
